// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the downstream active-low resets one stage at a time. While the
// stages are released it watches for lock loss, and it counts lock timeouts
// and lock losses.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_STAGES     = 3,
    parameter int STAGE_GAP      = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  lock,
    output logic                  pll_reset,
    output logic [NUM_STAGES-1:0] resetn_out,
    output logic                  ready,
    output logic [3:0]            retry_cnt,
    output logic [7:0]            loss_cnt
);

    // One timer serves every state, so it is sized for the longest interval.
    // The release span is included so that unusual stage/gap settings still fit.
    localparam int REL_SPAN = (NUM_STAGES - 1) * STAGE_GAP;
    localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B    = (STABLE_CYCLES > REL_SPAN) ? STABLE_CYCLES : REL_SPAN;
    localparam int MAX_P    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW       = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t                  state;
    logic [TW-1:0]           timer;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    lock_s;
    logic [NUM_STAGES-1:0]   stage_due;
    logic                    lost;

    // Bring the asynchronous lock into the clk domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Stage i is released when the release timer reaches i*STAGE_GAP-1.
    // Stage 0 is released on entry to RELEASE, so it never comes due here.
    assign stage_due[0] = 1'b0;
    for (genvar i = 1; i < NUM_STAGES; i++) begin : g_stage
        assign stage_due[i] = (timer == TW'(i * STAGE_GAP - 1));
    end

    // Losing lock after any stage is released takes priority over all other events.
    assign lost = !lock_s && (state == S_RELEASE || state == S_RUN);

    // Sequencer FSM. All outputs are registered here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_PLL_RST;
            timer      <= '0;
            pll_reset  <= 1'b1;
            resetn_out <= '0;
            ready      <= 1'b0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
        end else if (lost) begin
            state      <= S_PLL_RST;
            timer      <= '0;
            pll_reset  <= 1'b1;
            resetn_out <= '0;
            ready      <= 1'b0;
            if (loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (timer == TW'(PLL_RST_CYCLES - 1)) begin
                        state     <= S_WAIT_LOCK;
                        timer     <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        timer <= '0;
                    end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                        state     <= S_PLL_RST;
                        timer     <= '0;
                        pll_reset <= 1'b1;
                        if (retry_cnt != 4'hF) retry_cnt <= retry_cnt + 4'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STABLE: begin
                    // A dropout here is treated as a glitch. It restarts the
                    // wait but is not counted.
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == TW'(STABLE_CYCLES - 1)) begin
                        timer         <= '0;
                        resetn_out[0] <= 1'b1;
                        if (NUM_STAGES == 1) begin
                            state <= S_RUN;
                            ready <= 1'b1;
                        end else begin
                            state <= S_RELEASE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RELEASE: begin
                    resetn_out <= resetn_out | stage_due;
                    if (stage_due[NUM_STAGES-1]) begin
                        state <= S_RUN;
                        timer <= '0;
                        ready <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RUN: begin
                    timer <= '0;
                end
                default: begin
                    state     <= S_PLL_RST;
                    timer     <= '0;
                    pll_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer. A timestamp-based reference model tracks when
// the current PLL pulse started, when lock was first seen and when stage 0
// was released. Expected outputs are derived from those times every cycle.
module tb_pll_reset_sequencer;

    localparam int PRST = 4;
    localparam int TO   = 32;
    localparam int STB  = 8;
    localparam int NS   = 3;
    localparam int GAP  = 4;
    localparam int SYNC = 2;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          lock   = 1'b0;
    logic          pll_reset;
    logic [NS-1:0] resetn_out;
    logic          ready;
    logic [3:0]    retry_cnt;
    logic [7:0]    loss_cnt;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(PRST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB),
        .NUM_STAGES(NS), .STAGE_GAP(GAP), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .resetn(resetn), .lock(lock), .pll_reset(pll_reset),
        .resetn_out(resetn_out), .ready(ready), .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state. All values are cycle numbers counted from the release of resetn.
    int   n;          // current cycle
    int   seq_start;  // cycle in which the current PLL reset pulse began
    int   win_start;  // cycle in which the current lock wait window began
    int   lock_c;     // cycle in which lock_s was first seen high, -1 if none yet
    int   rel0;       // cycle in which stage 0 is released, -1 if not yet
    int   m_retry;
    int   m_loss;
    logic h1, h2;     // lock as driven one and two cycles ago
    bit   mon_en = 1'b0;

    logic [16:0] dut_vec;
    assign dut_vec = {pll_reset, resetn_out, ready, retry_cnt, loss_cnt};

    function automatic logic [16:0] exp_vec();
        logic [NS-1:0] e_rst;
        logic          e_pll, e_rdy;
        e_pll = (n >= seq_start) && (n < seq_start + PRST);
        for (int i = 0; i < NS; i++) e_rst[i] = (rel0 >= 0) && (n >= rel0 + i * GAP);
        e_rdy = (rel0 >= 0) && (n >= rel0 + (NS - 1) * GAP);
        return {e_pll, e_rst, e_rdy, m_retry[3:0], m_loss[7:0]};
    endfunction

    task automatic model_reset();
        n = 0; seq_start = 0; win_start = PRST; lock_c = -1; rel0 = -1;
        m_retry = 0; m_loss = 0; h1 = 1'b0; h2 = 1'b0;
    endtask

    // Drive lock for cycle n, step one clock and update the model for the
    // decision taken at the end of that cycle.
    task automatic cyc(input logic l);
        logic ls;
        lock = l;
        ls = h2; h2 = h1; h1 = l;
        @(posedge clk);
        if (n >= seq_start + PRST) begin
            if (rel0 < 0) begin
                if (lock_c < 0) begin
                    if (ls) lock_c = n;
                    else if (n == win_start + TO - 1) begin
                        if (m_retry < 15) m_retry++;
                        seq_start = n + 1;
                        win_start = n + 1 + PRST;
                    end
                end else begin
                    if (!ls) begin
                        lock_c = -1;
                        win_start = n + 1;
                    end else if (n == lock_c + STB) begin
                        rel0 = n + 1;
                    end
                end
            end else if (!ls) begin
                if (m_loss < 255) m_loss++;
                seq_start = n + 1;
                win_start = n + 1 + PRST;
                lock_c = -1;
                rel0 = -1;
            end
        end
        n++;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    // Cycle-by-cycle scoreboard against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL model cyc=%0d got=%05h want=%05h", n, dut_vec, exp_vec());
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        lock = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        mon_en = 1'b0;
        resetn = 1'b0;
        lock = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== 17'h10000) begin
            errors++;
            $display("FAIL reset_state got=%05h want=%05h", dut_vec, 17'h10000);
        end
        lock = 1'b0;
        model_reset();
        resetn = 1'b1;
        #1;
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL cycle0 got=%05h want=%05h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_clean_start();
        int r0, r1, r2, rd, pll_cyc;
        r0 = -1; r1 = -1; r2 = -1; rd = -1; pll_cyc = 0;
        do_reset();
        if (pll_reset) pll_cyc++;
        for (int k = 0; k < 60; k++) begin
            cyc(n >= 20);
            if (pll_reset) pll_cyc++;
            if (resetn_out[0] && r0 < 0) r0 = n;
            if (resetn_out[1] && r1 < 0) r1 = n;
            if (resetn_out[2] && r2 < 0) r2 = n;
            if (ready && rd < 0) rd = n;
        end
        checks++;
        if (pll_cyc !== 4) begin errors++; $display("FAIL clean_pll_width got=%0d want=4", pll_cyc); end
        checks++;
        if (r0 !== 31) begin errors++; $display("FAIL clean_stage0 got=%0d want=31", r0); end
        checks++;
        if (r1 !== 35) begin errors++; $display("FAIL clean_stage1 got=%0d want=35", r1); end
        checks++;
        if (r2 !== 39 || rd !== 39) begin
            errors++; $display("FAIL clean_stage2_ready got=%0d/%0d want=39/39", r2, rd);
        end
        checks++;
        if ({retry_cnt, loss_cnt} !== 12'h000) begin
            errors++; $display("FAIL clean_counters got=%03h want=000", {retry_cnt, loss_cnt});
        end
    endtask

    task automatic test_no_lock();
        int  first_retry;
        logic any_rel;
        first_retry = -1; any_rel = 1'b0;
        do_reset();
        for (int k = 0; k < 620; k++) begin
            cyc(1'b0);
            if (retry_cnt == 4'd1 && first_retry < 0) first_retry = n;
            any_rel |= |resetn_out;
        end
        checks++;
        if (first_retry !== 36) begin errors++; $display("FAIL first_retry got=%0d want=36", first_retry); end
        checks++;
        if (retry_cnt !== 4'd15) begin errors++; $display("FAIL retry_sat got=%0d want=15", retry_cnt); end
        checks++;
        if (any_rel !== 1'b0) begin errors++; $display("FAIL nolock_release got=%b want=0", any_rel); end
    endtask

    task automatic test_glitch();
        int r0;
        r0 = -1;
        do_reset();
        for (int k = 0; k < 60; k++) begin
            cyc(n >= 20 && n != 26);
            if (resetn_out[0] && r0 < 0) r0 = n;
        end
        checks++;
        if (r0 !== 38) begin errors++; $display("FAIL glitch_stage0 got=%0d want=38", r0); end
        checks++;
        if (loss_cnt !== 8'd0) begin errors++; $display("FAIL glitch_loss got=%0d want=0", loss_cnt); end
    endtask

    task automatic test_run_loss();
        int g, d, t_lo;
        do_reset();
        g = 0;
        while (!ready && g < 100) begin cyc(n >= 5); g++; end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL run_reach got=%b want=1", ready); end
        d = n; t_lo = -1;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0);
            if (!ready && t_lo < 0) t_lo = n - d;
        end
        checks++;
        if (t_lo !== SYNC + 1) begin errors++; $display("FAIL loss_latency got=%0d want=%0d", t_lo, SYNC + 1); end
        checks++;
        if ({resetn_out, loss_cnt} !== {3'b000, 8'd1}) begin
            errors++; $display("FAIL run_loss got=%b/%0d want=000/1", resetn_out, loss_cnt);
        end
        g = 0;
        while (!ready && g < 100) begin cyc(1'b1); g++; end
        checks++;
        if ({ready, loss_cnt} !== 9'h101) begin
            errors++; $display("FAIL relock got=%b/%0d want=1/1", ready, loss_cnt);
        end
    endtask

    task automatic test_mid_release();
        int g;
        logic seen1;
        do_reset();
        g = 0;
        while (!resetn_out[0] && g < 60) begin cyc(n >= 3); g++; end
        checks++;
        if (resetn_out[0] !== 1'b1) begin errors++; $display("FAIL midrel_reach got=%b want=1", resetn_out[0]); end
        seen1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0);
            seen1 |= resetn_out[1];
        end
        checks++;
        if (seen1 !== 1'b0) begin errors++; $display("FAIL midrel_stage1 got=%b want=0", seen1); end
        checks++;
        if ({resetn_out, loss_cnt} !== {3'b000, 8'd1}) begin
            errors++; $display("FAIL midrel_loss got=%b/%0d want=000/1", resetn_out, loss_cnt);
        end
    endtask

    task automatic test_async_reset();
        int g;
        do_reset();
        g = 0;
        while (!resetn_out[0] && g < 60) begin cyc(1'b1); g++; end
        cyc(1'b1);
        cyc(1'b1);
        mon_en = 1'b0;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 17'h10000) begin
            errors++; $display("FAIL async_reset got=%05h want=%05h", dut_vec, 17'h10000);
        end
    endtask

    task automatic test_loss_sat();
        int g;
        do_reset();
        for (int it = 0; it < 260; it++) begin
            g = 0;
            while (!resetn_out[0] && g < 60) begin cyc(1'b1); g++; end
            if (!resetn_out[0]) begin
                checks++; errors++;
                $display("FAIL loss_sat_timeout iter=%0d got=0 want=1", it);
                break;
            end
            repeat (3) cyc(1'b0);
        end
        checks++;
        if (loss_cnt !== 8'd255) begin errors++; $display("FAIL loss_sat got=%0d want=255", loss_cnt); end
    endtask

    task automatic test_random();
        logic level;
        int   run;
        do_reset();
        level = 1'b0; run = 0;
        for (int k = 0; k < 3000; k++) begin
            if (run == 0) begin
                level = !level;
                if (level) run = $urandom_range(1, 50);
                else if ($urandom_range(0, 3) == 0) run = $urandom_range(20, 45);
                else run = $urandom_range(1, 4);
            end
            cyc(level);
            run--;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_start();
        test_no_lock();
        test_glitch();
        test_run_loss();
        test_mid_release();
        test_async_reset();
        test_loss_sat();
        test_random();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumes the PLL `lock` output and drives the PLL `RESET` input.
- Runs on the free-running 50 MHz board clock, the same one that feeds the PLL `clkin`.
- Generates staged, active-low reset releases for the downstream clock-domain logic: SDRAM controller, PPU/APU, HDMI.
- Supervises lock: handles lock timeout retries, lock-loss recovery and diagnostic counters.

Parameters:
- PLL_RST_CYCLES, 16: cycles `pll_reset` is held high per PLL reset pulse (>=1).
- LOCK_TIMEOUT, 65536: cycles to wait for lock after a PLL reset before retrying (>=2).
- STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release (>=1).
- NUM_STAGES, 3: number of staged reset outputs (>=1).
- STAGE_GAP, 16: cycles between successive stage releases (>=1).
- SYNC_STAGES, 2: flops in the `lock` synchronizer (>=2).

Ports:
- clk  in  1  50 MHz reference clock; one clock domain, all logic on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- lock  in  1  PLL lock, asynchronous to clk.
- pll_reset  out  1  to PLL RESET, active high.
- resetn_out  out  NUM_STAGES  staged active-low resets; bit 0 released first.
- ready  out  1  all stages released, lock stable.
- retry_cnt  out  4  lock-timeout retries since resetn, saturating at 15.
- loss_cnt  out  8  lock-loss events in RUN/RELEASE, saturating at 255.

Behaviour:
- Reset (async, resetn=0):
  - state=PLL_RST, pll_reset=1, resetn_out=0, ready=0, retry_cnt=0, loss_cnt=0.
  - All timers and synchronizer flops cleared.
  - Takes effect immediately in any state, including mid-RELEASE.
- Lock synchronization: lock_s = lock delayed through SYNC_STAGES flops; only lock_s is used internally.
- Timer: a single counter, sized by $clog2 of the largest parameter, is cleared on every state transition.
- PLL_RST:
  - pll_reset=1 for exactly PLL_RST_CYCLES cycles, then -> WAIT_LOCK.
  - pll_reset is registered and falls the cycle the state becomes WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - Timer reaching LOCK_TIMEOUT-1 with lock_s=0 -> retry_cnt+1 (saturating) and -> PLL_RST.
- STABLE:
  - Timer counts while lock_s=1.
  - lock_s=0 -> WAIT_LOCK. This is a glitch: not counted, outputs unchanged.
  - Timer==STABLE_CYCLES-1 -> RELEASE.
- RELEASE:
  - resetn_out[0] goes to 1 on the entry edge.
  - resetn_out[i] goes to 1 exactly i*STAGE_GAP cycles after resetn_out[0].
  - On the edge that sets resetn_out[NUM_STAGES-1], ready=1 and -> RUN.
  - With NUM_STAGES=1, ready rises together with resetn_out[0].
- Lock loss (RUN or RELEASE, lock_s=0):
  - Next edge: resetn_out=0, ready=0, loss_cnt+1 (saturating), -> PLL_RST (pll_reset=1 the same edge).
- Release latency: resetn_out[0] rises exactly STABLE_CYCLES+1 cycles after the first cycle lock_s is high in WAIT_LOCK.
- Monotonicity: resetn_out bits never release out of order, and never release while lock_s=0.
- Simultaneous events: if lock_s falls on the same cycle a release or transition is due, the lock-loss/glitch path wins.
- Counters hold their value across lock-loss cycles. Only resetn clears them.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, NUM_STAGES=3, STAGE_GAP=4, SYNC_STAGES=2.
- Clean start, lock rises at cycle 20 and is held -> pll_reset high cycles 0-3; resetn_out[0] rises 11 cycles after the lock edge; [1] +4; [2] +8 with ready=1; retry_cnt=0, loss_cnt=0.
- Lock never asserts -> pll_reset 4-cycle pulses every 36 cycles; retry_cnt 1,2,...,15, then holds at 15; resetn_out stays 0.
- 1-cycle lock drop at STABLE count 5 -> no output change, loss_cnt=0; the stable count restarts and resetn_out[0] release is delayed accordingly.
- Lock drop in RUN -> resetn_out=0 and ready=0 within SYNC_STAGES+1 cycles; loss_cnt=1; 4-cycle pll_reset pulse; full re-sequence after relock.
- Lock drop mid-RELEASE, after stage 0 released and before stage 1 -> all stages back to 0, loss_cnt+1, stage 1 never released early.
- resetn pulsed low mid-RELEASE -> outputs return to reset values asynchronously; 260 forced losses -> loss_cnt=255.
